// File: rtl/tea_pkg.sv
// tea_pkg: shared TEA defaults, key-store address width and engine state encoding
package tea_pkg;
  localparam int WORD_SIZE_DEF = 32;
  localparam logic [31:0] DELTA_DEF = 32'h9e3779b9;
  localparam int ROUND_NUMBER_DEF = 32;
  localparam int KEY_ADDR_W = 2;
  typedef enum logic [2:0] {IDLE, KEY_FETCH, READY, ROUND, DONE} teaState;
endpackage

// File: rtl/tea_round.sv
// tea_round: one combinational TEA round, encrypt or decrypt
module tea_round import tea_pkg::*; #(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter logic [WORD_SIZE-1:0] DELTA = WORD_SIZE'(DELTA_DEF)
) (
  input  logic [WORD_SIZE-1:0] v0,
  input  logic [WORD_SIZE-1:0] v1,
  input  logic [WORD_SIZE-1:0] sum,
  input  logic [WORD_SIZE-1:0] k0,
  input  logic [WORD_SIZE-1:0] k1,
  input  logic [WORD_SIZE-1:0] k2,
  input  logic [WORD_SIZE-1:0] k3,
  input  logic                 decrypt,
  output logic [WORD_SIZE-1:0] nextV0,
  output logic [WORD_SIZE-1:0] nextV1,
  output logic [WORD_SIZE-1:0] nextSum
);
  function automatic logic [WORD_SIZE-1:0] mix(input logic [WORD_SIZE-1:0] v, s, ka, kb);
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction
  logic [WORD_SIZE-1:0] encSum, encV0, decV1;
  always_comb begin
    encSum = sum + DELTA;
    encV0 = v0 + mix(v1, encSum, k0, k1);
    decV1 = v1 - mix(v0, sum, k2, k3);
    nextSum = decrypt ? sum - DELTA : encSum;
    nextV0 = decrypt ? v0 - mix(decV1, sum, k0, k1) : encV0;
    nextV1 = decrypt ? decV1 : v1 + mix(encV0, encSum, k2, k3);
  end
endmodule

// File: rtl/tea_stream_engine.sv
// tea_stream_engine: iterative TEA engine, one round per clock, valid/ready block streaming.
// Define TEA_STREAM_CBC_EN to build CBC chaining; otherwise the engine is pure ECB.
module tea_stream_engine import tea_pkg::*; #(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter logic [WORD_SIZE-1:0] DELTA = WORD_SIZE'(DELTA_DEF),
  parameter int ROUND_NUMBER = ROUND_NUMBER_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iKeyLoad,
  output logic [KEY_ADDR_W-1:0] oKey_address,
  input  logic [WORD_SIZE-1:0]  iKey_sub_i,
  output logic                  oKeyReady,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic                  iDecrypt,
  input  logic [WORD_SIZE-1:0]  iV0,
  input  logic [WORD_SIZE-1:0]  iV1,
  input  logic                  iIvLoad,
  input  logic [WORD_SIZE-1:0]  iIv0,
  input  logic [WORD_SIZE-1:0]  iIv1,
  output logic                  oValid,
  input  logic                  iOutReady,
  output logic [WORD_SIZE-1:0]  oC0,
  output logic [WORD_SIZE-1:0]  oC1
);
  localparam logic [7:0] LAST_ROUND = 8'(ROUND_NUMBER - 1);
  localparam logic [WORD_SIZE-1:0] DEC_SUM = DELTA * WORD_SIZE'(ROUND_NUMBER);
  teaState state, nextState;
  logic [2:0] fetchCnt;
  logic [7:0] roundCnt;
  logic [WORD_SIZE-1:0] key [4];
  logic [WORD_SIZE-1:0] v0, v1, sum, rV0, rV1, rSum;
  logic [WORD_SIZE-1:0] inXor0, inXor1, outXor0, outXor1;
  logic decrypt, accept, outTake;
  assign accept = state == READY && iValid && !iKeyLoad;
  assign outTake = state == DONE && iOutReady;
  assign oReady = state == READY;
  assign oKey_address = (state == KEY_FETCH && !fetchCnt[2]) ? fetchCnt[KEY_ADDR_W-1:0] : '0;
  tea_round #(.WORD_SIZE(WORD_SIZE), .DELTA(DELTA)) round (
    .v0(v0), .v1(v1), .sum(sum),
    .k0(key[0]), .k1(key[1]), .k2(key[2]), .k3(key[3]),
    .decrypt(decrypt),
    .nextV0(rV0), .nextV1(rV1), .nextSum(rSum)
  );
  always_ff @(posedge clk) state <= !rst ? IDLE : nextState;
  always_comb begin
    nextState = state;
    case (state)
      IDLE:      nextState = iKeyLoad ? KEY_FETCH : IDLE;
      KEY_FETCH: nextState = fetchCnt == 3'd4 ? READY : KEY_FETCH;
      READY:     nextState = iKeyLoad ? KEY_FETCH : iValid ? ROUND : READY;
      ROUND:     nextState = roundCnt == LAST_ROUND ? DONE : ROUND;
      DONE:      nextState = iOutReady ? READY : DONE;
      default:   nextState = IDLE;
    endcase
  end
  // Key word for address n arrives one cycle later, so capture lags the address by one count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetchCnt <= '0;
      roundCnt <= '0;
      key <= '{default: '0};
      v0 <= '0;
      v1 <= '0;
      sum <= '0;
      decrypt <= 1'b0;
      oKeyReady <= 1'b0;
      oValid <= 1'b0;
      oC0 <= '0;
      oC1 <= '0;
    end else begin
      if ((state == IDLE || state == READY) && iKeyLoad) begin
        fetchCnt <= '0;
        oKeyReady <= 1'b0;
      end
      if (state == KEY_FETCH) begin
        fetchCnt <= fetchCnt + 3'd1;
        if (fetchCnt != 3'd0) key[fetchCnt[1:0] - 2'd1] <= iKey_sub_i;
        if (fetchCnt == 3'd4) oKeyReady <= 1'b1;
      end
      if (accept) begin
        v0 <= iV0 ^ inXor0;
        v1 <= iV1 ^ inXor1;
        decrypt <= iDecrypt;
        sum <= iDecrypt ? DEC_SUM : '0;
        roundCnt <= '0;
      end
      if (state == ROUND) begin
        v0 <= rV0;
        v1 <= rV1;
        sum <= rSum;
        roundCnt <= roundCnt + 8'd1;
        if (roundCnt == LAST_ROUND) begin
          oValid <= 1'b1;
          oC0 <= rV0 ^ outXor0;
          oC1 <= rV1 ^ outXor1;
        end
      end
      if (outTake) oValid <= 1'b0;
    end
  end
`ifdef TEA_STREAM_CBC_EN
  logic [WORD_SIZE-1:0] chain0, chain1, inC0, inC1, ivEff0, ivEff1;
  logic ivTake;
  assign ivTake = (state == IDLE || state == READY) && iIvLoad;
  // An IV load coinciding with a handshake must already chain that block.
  assign ivEff0 = ivTake ? iIv0 : chain0;
  assign ivEff1 = ivTake ? iIv1 : chain1;
  assign inXor0 = iDecrypt ? '0 : ivEff0;
  assign inXor1 = iDecrypt ? '0 : ivEff1;
  assign outXor0 = decrypt ? chain0 : '0;
  assign outXor1 = decrypt ? chain1 : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      chain0 <= '0;
      chain1 <= '0;
      inC0 <= '0;
      inC1 <= '0;
    end else begin
      if (ivTake) begin
        chain0 <= iIv0;
        chain1 <= iIv1;
      end
      if (accept) begin
        inC0 <= iV0;
        inC1 <= iV1;
      end
      if (outTake) begin
        chain0 <= decrypt ? inC0 : oC0;
        chain1 <= decrypt ? inC1 : oC1;
      end
    end
  end
`else
  logic unusedIv;
  assign unusedIv = ^{iIvLoad, iIv0, iIv1};
  assign inXor0 = '0;
  assign inXor1 = '0;
  assign outXor0 = '0;
  assign outXor1 = '0;
`endif
endmodule

// File: tb/tb_tea_stream_engine.sv
// tb_tea_stream_engine: scoreboard bench for tea_stream_engine (ECB, or CBC with TEA_STREAM_CBC_EN)
module tb_tea_stream_engine;
  localparam logic [31:0] DELTA = 32'h9e3779b9;
  localparam int LAT = 33;
  typedef struct {logic [31:0] c0, c1; int hs;} expT;
  logic clk = 0, rst = 0, iKeyLoad = 0, oKeyReady, iValid = 0, oReady, iDecrypt = 0;
  logic iIvLoad = 0, oValid, iOutReady = 1;
  logic [1:0] oKey_address;
  logic [31:0] iKey_sub_i = 0, iV0 = 0, iV1 = 0, iIv0 = 0, iIv1 = 0, oC0, oC1;
  logic [31:0] keyMem [4] = '{default: 0};
  logic [31:0] curKey [4] = '{default: 0};
  logic [63:0] tbChain = 0;
  expT sb[$];
  logic [31:0] got0[$], got1[$];
  int checks = 0, errors = 0, cyc = 0;
  logic wasValid = 0;

  tea_stream_engine dut (
    .clk(clk), .rst(rst), .iKeyLoad(iKeyLoad), .oKey_address(oKey_address),
    .iKey_sub_i(iKey_sub_i), .oKeyReady(oKeyReady), .iValid(iValid), .oReady(oReady),
    .iDecrypt(iDecrypt), .iV0(iV0), .iV1(iV1), .iIvLoad(iIvLoad), .iIv0(iIv0),
    .iIv1(iIv1), .oValid(oValid), .iOutReady(iOutReady), .oC0(oC0), .oC1(oC1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) iKey_sub_i <= keyMem[oKey_address];

  function automatic logic [63:0] tea(input logic [31:0] a, b, input logic dec);
    logic [31:0] s = dec ? 32'hc6ef3720 : 32'h0;
    for (int i = 0; i < 32; i++) begin
      if (!dec) begin
        s += DELTA;
        a += ((b << 4) + curKey[0]) ^ (b + s) ^ ((b >> 5) + curKey[1]);
        b += ((a << 4) + curKey[2]) ^ (a + s) ^ ((a >> 5) + curKey[3]);
      end else begin
        b -= ((a << 4) + curKey[2]) ^ (a + s) ^ ((a >> 5) + curKey[3]);
        a -= ((b << 4) + curKey[0]) ^ (b + s) ^ ((b >> 5) + curKey[1]);
        s -= DELTA;
      end
    end
    return {a, b};
  endfunction

  task automatic check(input string name, input logic [63:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    expT e;
    if (oValid && !wasValid && sb.size() > 0) check("output latency", 64'(cyc - sb[0].hs), 64'(LAT));
    wasValid <= oValid;
    if (oValid && iOutReady) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected output: got %h %h, expected none", oC0, oC1);
      end else begin
        e = sb.pop_front();
        check("output block", {oC0, oC1}, {e.c0, e.c1});
        got0.push_back(oC0);
        got1.push_back(oC1);
      end
    end
  end

  task automatic sendBlock(input logic [31:0] a, b, input logic d);
    int n = 0;
    logic [63:0] r;
    expT e;
    @(posedge clk);
    #1;
    iV0 = a; iV1 = b; iDecrypt = d; iValid = 1;
    @(negedge clk);
    while (!oReady && n < 200) begin @(negedge clk); n++; end
    if (!oReady) begin
      checks++;
      errors++;
      $display("FAIL handshake timeout: oReady=%b, expected 1", oReady);
    end else begin
`ifdef TEA_STREAM_CBC_EN
      if (!d) begin r = tea(a ^ tbChain[63:32], b ^ tbChain[31:0], 1'b0); tbChain = r; end
      else begin r = tea(a, b, 1'b1) ^ tbChain; tbChain = {a, b}; end
`else
      r = tea(a, b, d);
`endif
      e.c0 = r[63:32]; e.c1 = r[31:0]; e.hs = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 iValid = 0;
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || !oReady) && n < 500) begin @(negedge clk); n++; end
    check("drain timeout", 64'(sb.size() == 0 && oReady), 64'd1);
  endtask

  task automatic loadKey(input logic [31:0] k0, k1, k2, k3, input logic withValid);
    @(posedge clk);
    #1;
    keyMem = '{k0, k1, k2, k3};
    curKey = '{k0, k1, k2, k3};
    iKeyLoad = 1; iValid = withValid; iV0 = 32'h0badf00d; iV1 = 32'h5eed5eed; iDecrypt = 0;
    @(posedge clk);
    #1 iKeyLoad = 0; iValid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) check("key address", 64'(oKey_address), 64'(i));
      check("key ready timing", 64'(oKeyReady), 64'(i == 5));
      if (i == 0) check("ready during fetch", 64'(oReady), 64'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] c1a, c1b, c2a, c2b;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset oKeyReady", 64'(oKeyReady), 0);
    check("reset oReady", 64'(oReady), 0);
    check("reset oValid", 64'(oValid), 0);
    check("reset oC", {oC0, oC1}, 0);
    check("reset address", 64'(oKey_address), 0);
    @(posedge clk);
    #1 rst = 1; iValid = 1;
    repeat (3) begin @(negedge clk); check("idle ignores valid", 64'(oReady), 0); end
    iValid = 0;
    loadKey(0, 0, 0, 0, 0);
    sendBlock(0, 0, 0);
    waitIdle();
    check("zero key vector", {got0[$], got1[$]}, 64'h41ea3a0a94baa940);
    sendBlock(32'h41ea3a0a, 32'h94baa940, 1);
    waitIdle();
`ifndef TEA_STREAM_CBC_EN
    check("zero key decrypt", {got0[$], got1[$]}, 64'h0);
`endif
    iOutReady = 0;
    sendBlock(32'h12345678, 32'h9abcdef0, 0);
    n = 0;
    while (!oValid && n < 100) begin @(negedge clk); n++; end
    check("hold valid seen", 64'(oValid), 1);
    iValid = 1; iV0 = 32'h11111111; iV1 = 32'h22222222;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sb.size() > 0) check("hold oC stable", {oC0, oC1}, {sb[0].c0, sb[0].c1});
      check("hold oReady low", 64'(oReady), 0);
      check("hold oValid high", 64'(oValid), 1);
    end
    @(posedge clk);
    #1 iValid = 0; iOutReady = 1;
    @(negedge clk);
    @(negedge clk);
    check("ready after release", 64'(oReady), 1);
    loadKey(32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210, 1);
    sendBlock(32'h00000000, 32'h00000000, 0);
    sendBlock(32'hdeadbeef, 32'h01234567, 0);
    sendBlock(32'hffffffff, 32'hffffffff, 1);
    sendBlock(32'h80000000, 32'h00000001, 1);
    waitIdle();
    sendBlock(32'h55555555, 32'haaaaaaaa, 0);
    repeat (14) @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1 rst = 1;
    sb.delete();
    tbChain = 0;
    @(negedge clk);
    check("abort oValid", 64'(oValid), 0);
    check("abort oReady", 64'(oReady), 0);
    check("abort oKeyReady", 64'(oKeyReady), 0);
    iValid = 1;
    repeat (5) begin @(negedge clk); check("refuse before fetch", 64'(oReady), 0); end
    iValid = 0;
    loadKey(32'h3, 32'h1, 32'h4, 32'h1, 0);
    sendBlock(32'h00000001, 32'h00000002, 0);
    sendBlock(32'hcafebabe, 32'h0f0f0f0f, 1);
    waitIdle();
`ifdef TEA_STREAM_CBC_EN
    iIvLoad = 1; iIv0 = 1; iIv1 = 2;
    @(posedge clk);
    #1 iIvLoad = 0;
    tbChain = {32'd1, 32'd2};
    sendBlock(0, 0, 0);
    sendBlock(0, 0, 0);
    waitIdle();
    c1a = got0[got0.size() - 2]; c1b = got1[got1.size() - 2];
    c2a = got0[$]; c2b = got1[$];
    check("cbc ciphertexts differ", 64'({c1a, c1b} != {c2a, c2b}), 1);
    iIvLoad = 1;
    @(posedge clk);
    #1 iIvLoad = 0;
    tbChain = {32'd1, 32'd2};
    sendBlock(c1a, c1b, 1);
    sendBlock(c2a, c2b, 1);
    waitIdle();
    check("cbc first recovered", {got0[got0.size() - 2], got1[got1.size() - 2]}, 0);
    check("cbc second recovered", {got0[$], got1[$]}, 0);
`endif
    repeat (3) @(negedge clk);
    check("scoreboard empty", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tea_stream_engine.md
Name: tea_stream_engine

Overview:
- Iterative TEA block-cipher engine, one round per clock, with valid/ready streaming of 2-word blocks.
- Encrypt or decrypt is selectable per block.
- The 4-word key is fetched once from an external synchronous key store through an address port, then reused for every block until reloaded.
- Sits between the host data path and the key store; replaces separate cipher/decipher instances with a single shared datapath.

Parameters:
- WORD_SIZE, 32: width of each half-block and key word.
- DELTA, 32'h9e3779b9: key-schedule constant.
- ROUND_NUMBER, 32: rounds per block, legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- iKeyLoad  in  1  one-cycle pulse: fetch key words 0..3
- oKey_address  out  2  key-store word address
- iKey_sub_i  in  WORD_SIZE  key-store read data; valid one cycle after address
- oKeyReady  out  1  key held and valid
- iValid  in  1  input block valid
- oReady  out  1  engine can accept a block
- iDecrypt  in  1  0 = encrypt, 1 = decrypt; sampled at input handshake
- iV0, iV1  in  WORD_SIZE each  input half-blocks
- iIvLoad  in  1  load chaining value (CBC only)
- iIv0, iIv1  in  WORD_SIZE each  chaining value
- oValid  out  1  output block valid
- iOutReady  in  1  downstream accepts output
- oC0, oC1  out  WORD_SIZE each  result half-blocks

Behaviour:
- Reset (rst=0 at a clock edge), taking priority over everything, including mid-fetch and mid-round:
  - State returns to IDLE.
  - Outputs cleared: oKeyReady=0, oReady=0, oValid=0, oC0=oC1=0, oKey_address=0.
  - Key and chain registers cleared to 0.
- FSM states: IDLE, KEY_FETCH, READY, ROUND, DONE.
- IDLE:
  - iKeyLoad moves to KEY_FETCH.
  - iValid is ignored; oReady=0.
- KEY_FETCH:
  - oKey_address steps 0,1,2,3 over 4 cycles.
  - Each iKey_sub_i is captured one cycle after its address, so the fetch takes 5 cycles.
  - Then oKeyReady=1 and the FSM moves to READY.
- READY:
  - oReady=1.
  - iValid & oReady is the handshake: latch iV0/iV1/iDecrypt, init sum and round counter, go to ROUND.
  - iKeyLoad in READY restarts KEY_FETCH and deasserts oKeyReady. If iKeyLoad and iValid are both high, iKeyLoad wins and the block is not accepted.
- ROUND:
  - One round per cycle for ROUND_NUMBER cycles; oReady=0.
  - iKeyLoad and iIvLoad are ignored.
- Encrypt round:
  - sum+=DELTA
  - v0+=((v1<<4)+k0)^(v1+sum)^((v1>>5)+k1)
  - v1+=((v0'<<4)+k2)^(v0'+sum)^((v0'>>5)+k3)
- Decrypt round:
  - sum initialised to DELTA*ROUND_NUMBER truncated to WORD_SIZE.
  - v1-=… using v0; then v0-=… using v1'; then sum-=DELTA.
- Arithmetic and shifts:
  - All arithmetic is modulo 2^WORD_SIZE.
  - >> is a logical shift.
- Latency: handshake at cycle t; rounds in cycles t+1..t+ROUND_NUMBER; oValid=1 with oC0/oC1 registered from cycle t+ROUND_NUMBER+1.
- DONE:
  - oValid and oC0/oC1 are held stable until iOutReady=1.
  - On that edge oValid drops and the FSM returns to READY.
  - No new input is accepted while in DONE; oReady=0.
- Throughput: one block per ROUND_NUMBER+2 cycles when iOutReady is tied high.
- Round counter is 8 bits and wraps only at reset/new block.

Optional Feature:
- Macro: TEA_STREAM_CBC_EN.
- With the macro defined, CBC chaining is enabled:
  - iIvLoad in READY or IDLE loads chain <= {iIv0,iIv1}. It is ignored in any other state; if it coincides with a handshake, the load applies first.
  - Encrypt: the cipher input is V xor chain; output C; chain<=C.
  - Decrypt: output is D(C) xor chain; chain<=input C.
  - The chain updates at the DONE handshake.
- Without the macro: pure ECB.
  - iIvLoad, iIv0 and iIv1 remain as ports but are ignored.
  - No chain register is built.

Decomposition:
- Shared package tea_pkg holds:
  - WORD_SIZE, DELTA and ROUND_NUMBER defaults.
  - FSM state encoding (3-bit).
  - Key-address width (2).
- Natural sub-module tea_round: a purely combinational single round.
  - Inputs: v0, v1, sum, k0..k3, decrypt.
  - Outputs: next v0, next v1, next sum.
  - The engine instantiates it once.

Test Plan:
- Key store = {0,0,0,0}; encrypt V=(0,0), ROUND_NUMBER=32 -> C=(32'h41ea3a0a,32'h94baa940); oValid exactly 33 cycles after the handshake.
- Decrypt (32'h41ea3a0a,32'h94baa940) with the same key -> (0,0); oKey_address sequence during fetch is 0,1,2,3 and oKeyReady rises 5 cycles after iKeyLoad.
- Hold iOutReady=0 for 10 cycles after oValid -> oC0/oC1 stable, oReady=0, iValid ignored; release -> oReady=1 on the next cycle.
- Assert rst=0 at round 15 -> next cycle oValid=0, oReady=0, oKeyReady=0; a new block is refused until a new fetch completes.
- iKeyLoad and iValid high together in READY -> block not accepted, fetch restarts.
- TEA_STREAM_CBC_EN: IV=(1,2), encrypt two blocks of (0,0) and decrypt them back -> original (0,0),(0,0) recovered; the two ciphertexts differ.
